switch_conditioner: RTL and testbench

- Upstream front-end for the switch-pattern sequence detector.
- Takes 11 raw, asynchronous, bouncing slide-switch inputs and produces clean, debounced switch levels on `sw_stable`, which feed the detector's `switches` input.
- Bit 10 is the scan-enable switch; bits 9..0 are the pattern.
- Optionally freezes the pattern bits while enable is high, so the detector never scans a pattern that changes mid-scan. Also emits single-cycle edge strobes for status/display logic.

---
 rtl/switch_conditioner_pkg.sv | 8 +
 rtl/switch_conditioner_if.sv | 30 +++
 rtl/switch_debounce_bit.sv | 41 ++++
 rtl/switch_conditioner.sv | 62 ++++++
 tb/tb_switch_conditioner.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/switch_conditioner_pkg.sv
// Shared switch constants used by the conditioner and the pattern detector.
package switch_conditioner_pkg;

    localparam int unsigned SW_COUNT                = 11;
    localparam int unsigned SW_EN_IDX               = 10;
    localparam int unsigned DEBOUNCE_10MS_AT_100MHZ = 1000000;

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch bundle between the raw pins, the conditioner and its consumers.
interface switch_conditioner_if
    import switch_conditioner_pkg::*;
#(
    parameter int unsigned N_SW = SW_COUNT
) ();

    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_stable;
    logic            sw_changed;
    logic            en_rise;
    logic            en_fall;

    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_changed,
        input  en_rise,
        input  en_fall
    );

    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_changed,
        output en_rise,
        output en_fall
    );

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchronizer followed by a consecutive-cycle debounce counter.
module switch_debounce_bit
    import switch_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_100MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Any sample matching the accepted level restarts the run, so the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Debounces all slide switches, optionally freezes the pattern while scanning, and emits edge strobes.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int unsigned N_SW            = SW_COUNT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_100MHZ,
    parameter bit          LOCK_PATTERN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_conditioner_if.slave  bus
);

    localparam int unsigned EN_IDX = N_SW - 1;

    logic [N_SW-1:0] deb;
    logic [N_SW-1:0] stable;
    logic [N_SW-1:0] stable_c;
    logic            changed;
    logic            rise;
    logic            fall;

    for (genvar i = 0; i < int'(N_SW); i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk(clk),
            .rst(rst),
            .raw(bus.sw_raw[i]),
            .deb(deb[i])
        );
    end

    // Pattern follows deb unless the currently visible enable is holding it.
    always_comb begin
        stable_c         = stable;
        stable_c[EN_IDX] = deb[EN_IDX];
        if (!LOCK_PATTERN || !stable[EN_IDX]) begin
            stable_c[EN_IDX-1:0] = deb[EN_IDX-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable  <= '0;
            changed <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            stable  <= stable_c;
            changed <= (stable_c != stable);
            rise    <= stable_c[EN_IDX] & ~stable[EN_IDX];
            fall    <= ~stable_c[EN_IDX] & stable[EN_IDX];
        end
    end

    assign bus.sw_stable  = stable;
    assign bus.sw_changed = changed;
    assign bus.en_rise    = rise;
    assign bus.en_fall    = fall;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench: locked (dut0) and free-running (dut1) conditioners share one stimulus stream.
module tb_switch_conditioner;

    localparam int D = 4;

    typedef struct packed {
        logic [10:0] st;
        logic        ch;
        logic        ri;
        logic        fa;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] raw = 11'h7FF;

    switch_conditioner_if #(.N_SW(11)) bus0 ();
    switch_conditioner_if #(.N_SW(11)) bus1 ();

    assign bus0.sw_raw = raw;
    assign bus1.sw_raw = raw;

    switch_conditioner #(.N_SW(11), .DEBOUNCE_CYCLES(D), .LOCK_PATTERN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    switch_conditioner #(.N_SW(11), .DEBOUNCE_CYCLES(D), .LOCK_PATTERN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference: raw samples since reset; a bit's accepted level flips once the
    // last D compared samples (each two edges old) all disagree with it.
    logic [10:0] hist[$];
    logic [10:0] m_deb;
    int          last_flip[11];
    logic [10:0] m_stable[2];

    function automatic logic [10:0] samp(input int m);
        if (m < 0) return '0;
        return hist[m];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_deb = '0;
        for (int b = 0; b < 11; b++) last_flip[b] = -1000;
        m_stable[0] = '0;
        m_stable[1] = '0;
    endtask

    task automatic push_zero();
        q0.push_back('0);
        q1.push_back('0);
    endtask

    task automatic model_edge(input logic [10:0] v);
        int          n;
        exp_t        e;
        logic [10:0] ns;
        logic [10:0] s;
        logic [10:0] cur;
        bit          all_diff;
        n = hist.size();
        hist.push_back(v);
        for (int d = 0; d < 2; d++) begin
            cur = m_stable[d];
            ns[10] = m_deb[10];
            if (d == 0 && cur[10]) ns[9:0] = cur[9:0];
            else                   ns[9:0] = m_deb[9:0];
            e.st = ns;
            e.ch = (ns != cur);
            e.ri = ns[10] && !cur[10];
            e.fa = !ns[10] && cur[10];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            m_stable[d] = ns;
        end
        for (int b = 0; b < 11; b++) begin
            if (n - last_flip[b] >= D) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    s = samp(n - j - 2);
                    if (s[b] == m_deb[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_deb[b]     = ~m_deb[b];
                    last_flip[b] = n;
                end
            end
        end
    endtask

    task automatic check(input int d, input string what, input exp_t want, input exp_t got);
        tests++;
        if (got !== want) begin
            errors++;
            $display("FAIL dut%0d %s t=%0t: got st=%h ch=%b ri=%b fa=%b, want st=%h ch=%b ri=%b fa=%b",
                     d, what, $time, got.st, got.ch, got.ri, got.fa, want.st, want.ch, want.ri, want.fa);
        end
    endtask

    function automatic exp_t sample0();
        return {bus0.sw_stable, bus0.sw_changed, bus0.en_rise, bus0.en_fall};
    endfunction

    function automatic exp_t sample1();
        return {bus1.sw_stable, bus1.sw_changed, bus1.en_rise, bus1.en_fall};
    endfunction

    // Monitor: one expectation per edge, compared away from the active edge.
    always @(negedge clk) begin
        if (q0.size() > 0) check(0, "cycle", q0.pop_front(), sample0());
        if (q1.size() > 0) check(1, "cycle", q1.pop_front(), sample1());
    end

    task automatic cycle(input logic [10:0] v, input bit release_rst = 1'b0);
        @(posedge clk);
        #1;
        if (release_rst) rst = 1'b0;
        raw = v;
        if (rst) push_zero();
        else     model_edge(v);
    endtask

    task automatic hold(input logic [10:0] v, input int n);
        repeat (n) cycle(v);
    endtask

    // Mid-cycle reset: outputs must clear without waiting for an edge.
    task automatic async_reset(input int n);
        #2;
        rst = 1'b1;
        #1;
        check(0, "async_rst", '0, sample0());
        check(1, "async_rst", '0, sample1());
        q0.delete();
        q1.delete();
        push_zero();
        push_zero();
        model_reset();
        repeat (n) cycle(raw);
        cycle(raw, 1'b1);
    endtask

    logic [10:0] rv;

    initial begin
        model_reset();
        push_zero();
        // reset held with all switches on, then a clean single-bit rise
        hold(11'h7FF, 3);
        cycle(11'h001, 1'b1);
        hold(11'h001, 10);
        // bounce on bit 3
        cycle(11'h009);
        cycle(11'h001);
        cycle(11'h009);
        cycle(11'h001);
        cycle(11'h009);
        hold(11'h009, 10);
        // enable with pattern, change pattern while enabled, then drop enable
        hold(11'h6D5, 10);
        hold(11'h4AA, 12);
        hold(11'h0AA, 10);
        // simultaneous enable and pattern acceptance
        hold(11'h000, 10);
        hold(11'h5B1, 10);
        // reset in the middle of an enable debounce
        hold(11'h000, 10);
        hold(11'h400, 2);
        async_reset(2);
        hold(11'h400, 10);
        // randomized segments of varying hold length
        for (int seg = 0; seg < 120; seg++) begin
            if (seg % 4 == 0) rv = 11'($urandom);
            else              rv = raw ^ (11'($urandom) & 11'($urandom));
            hold(rv, int'($urandom_range(1, 8)));
            if (seg % 37 == 20) async_reset(int'($urandom_range(1, 3)));
        end
        hold(raw, 10);
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
